fixed_point_divider: RTL and testbench
======================================

Name: fixed_point_divider

Overview:
- Sequential sign-magnitude fixed-point divider; the inverse-direction companion to the RLS datapath multiplier.
- Used where the RLS update needs a division, e.g. the gain denominator reciprocal.
- Restoring radix-2 algorithm, one quotient bit per clock, start/ready/done handshake.
- Operand and result format: MSB = sign, remaining nBits-1 bits = magnitude with nFrac fractional bits.

Parameters:
- nBits, 32, total word width including sign bit.
- nFrac, 16, fractional bits of the magnitude; must satisfy 0 <= nFrac < nBits-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when ready=1.
- a  input  nBits  dividend, sign-magnitude; sampled with start.
- b  input  nBits  divisor, sign-magnitude; sampled with start.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse; res/ovf/dz valid from this cycle.
- res  output  nBits  quotient, sign-magnitude; held until the next accepted start.
- ovf  output  1  quotient magnitude saturated; held like res.
- dz  output  1  divide-by-zero; held like res.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ready=1, done=0, res=0, ovf=0, dz=0, all internal registers 0. Reset mid-division aborts with no done pulse.
- Width rules:
  - M = nBits-1, N = M+nFrac.
  - Dividend = |a| zero-extended and shifted left by nFrac (N bits).
  - Divisor = |b| (M bits); partial remainder register M+1 bits.
  - Quotient register N bits; result truncated toward zero, no rounding.
- States:
  - IDLE: start=1 latches operands, computes sign = a[nBits-1]^b[nBits-1], clears ovf/dz.
    - If |b|=0: go to DONE.
    - Else: iteration counter = N, go to DIV.
  - DIV: each cycle shift remainder left, bring in next dividend bit, trial-subtract |b|. If non-negative, keep the difference and set quotient bit; else restore. Decrement counter; at counter=1 go to DONE.
  - DONE: done=1 for exactly one cycle, res/ovf/dz registered this cycle, then unconditionally back to IDLE.
- Latency:
  - With start sampled at edge 0, done is high in the cycle after edge N+1. Defaults: 48 cycles.
  - Divide-by-zero: done high after edge 1.
- start while ready=0 (DIV or DONE) is ignored and not queued. Back-to-back: start may be asserted in the cycle after DONE.
- Saturation:
  - Quotient bits [N-1:M] nonzero → magnitude = all ones, ovf=1.
  - Otherwise magnitude = quotient[M-1:0].
- Divide-by-zero (|b|=0, either sign):
  - dz=1, ovf=0.
  - If |a|≠0: res = {a[nBits-1], all ones}.
  - If |a|=0: res = 0.
- Negative zero: never produced. If the result magnitude is 0, the sign bit is forced to 0. -0 inputs behave as 0.
- a and b may change freely after the start cycle; the block uses only latched copies.

Decomposition:
- Shared package fixed_point_pkg:
  - state enum {IDLE, DIV, DONE}.
  - localparam functions for M and N.
  - sign-magnitude helpers (sign bit, magnitude extract, zero test).
- One natural sub-module, div_restoring_step: combinational single iteration (remainder_in, next dividend bit, divisor → remainder_out, q_bit). The FSM, counter, saturation and sign logic stay in fixed_point_divider.

Test Plan:
Defaults nBits=32, nFrac=16.
1. a=0x00030000 (3.0), b=0x00020000 (2.0), start pulse → after 48 cycles done=1 for one cycle, res=0x00018000, ovf=0, dz=0; ready low throughout, high the cycle after done.
2. a=0x80010000 (-1.0), b=0x00040000 (4.0) → res=0x80004000. Then a=0x00010000, b=0x00030000 → res=0x00005555 (truncation).
3. a=0x7FFF0000, b=0x00000001 → res=0x7FFFFFFF, ovf=1. Then a=0x00000001, b=0x80020000 → magnitude 0, res=0x00000000 (no -0).
4. Divide by zero:
   - a=0x00050000, b=0x80000000 → done after 1 cycle, res=0x7FFFFFFF, dz=1.
   - a=0x80000000, b=0 → res=0, dz=1.
5. Start ignored: start with 3.0/2.0, pulse start again at cycle 10 with other operands → only one done at cycle 48, result 0x00018000.
6. Reset mid-op:
   - Drop rst_n at cycle 20 of a division → outputs zero immediately, ready=1, no done pulse.
   - After release, a fresh 1.0/2.0 division returns 0x00008000.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// Shared types and sign-magnitude helpers for the fixed-point divider.
package fixed_point_pkg;

   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

   function automatic int unsigned calc_m(input int unsigned nbits);
      return nbits - 1;
   endfunction

   function automatic int unsigned calc_n(input int unsigned nbits, input int unsigned nfrac);
      return nbits - 1 + nfrac;
   endfunction

   // Helpers operate on words zero-extended to 64 bits so they stay width-generic.
   function automatic logic sm_sign(input logic [63:0] x, input int unsigned nbits);
      return ((x >> (nbits - 1)) & 64'd1) != 64'd0;
   endfunction

   function automatic logic [63:0] sm_mag(input logic [63:0] x, input int unsigned nbits);
      return x & ((64'd1 << (nbits - 1)) - 64'd1);
   endfunction

   function automatic logic sm_is_zero(input logic [63:0] x, input int unsigned nbits);
      return sm_mag(x, nbits) == 64'd0;
   endfunction

endpackage

// File: rtl/fixed_point_divider_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, restore on borrow.
module div_restoring_step #(
   parameter int unsigned M = 31
) (
   input  logic [M:0]   rem_in,
   input  logic         dvd_bit,
   input  logic [M-1:0] divisor,
   output logic [M:0]   rem_out,
   output logic         q_bit
);

   logic [M+1:0] wide;

   assign wide    = {rem_in, dvd_bit};
   assign q_bit   = wide >= (M+2)'(divisor);
   assign rem_out = q_bit ? (M+1)'(wide - (M+2)'(divisor)) : (M+1)'(wide);

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential sign-magnitude fixed-point divider, restoring radix-2, one quotient bit per clock.
module fixed_point_divider
   import fixed_point_pkg::*;
#(
   parameter int unsigned nBits = 32,
   parameter int unsigned nFrac = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [nBits-1:0] a,
   input  logic [nBits-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [nBits-1:0] res,
   output logic             ovf,
   output logic             dz
);

   localparam int unsigned M  = calc_m(nBits);
   localparam int unsigned N  = calc_n(nBits, nFrac);
   localparam int unsigned CW = $clog2(N + 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N-1:0]     dvd_q, dvd_d;
   logic [N-1:0]     quot_q, quot_d;
   logic [M:0]       rem_q, rem_d;
   logic [M-1:0]     dsr_q, dsr_d;
   logic             sign_q, sign_d;
   logic             a_sign_q, a_sign_d;
   logic             a_zero_q, a_zero_d;
   logic             zdiv_q, zdiv_d;
   logic             done_q, done_d;
   logic [nBits-1:0] res_q, res_d;
   logic             ovf_q, ovf_d;
   logic             dz_q, dz_d;

   logic [M:0]       step_rem;
   logic             step_q;
   logic [M-1:0]     mag;

   div_restoring_step #(.M(M)) u_step (
      .rem_in  (rem_q),
      .dvd_bit (dvd_q[N-1]),
      .divisor (dsr_q),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   // Quotient bits above the result magnitude mean the true value does not fit.
   assign mag = (|(quot_q >> M)) ? {M{1'b1}} : quot_q[M-1:0];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dvd_d    = dvd_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
      dsr_d    = dsr_q;
      sign_d   = sign_q;
      a_sign_d = a_sign_q;
      a_zero_d = a_zero_q;
      zdiv_d   = zdiv_q;
      done_d   = 1'b0;
      res_d    = res_q;
      ovf_d    = ovf_q;
      dz_d     = dz_q;
      unique case (state_q)
         IDLE: begin
            if (start && ready) begin
               sign_d   = sm_sign(64'(a), nBits) ^ sm_sign(64'(b), nBits);
               a_sign_d = sm_sign(64'(a), nBits);
               a_zero_d = sm_is_zero(64'(a), nBits);
               zdiv_d   = sm_is_zero(64'(b), nBits);
               dsr_d    = M'(sm_mag(64'(b), nBits));
               dvd_d    = N'(sm_mag(64'(a), nBits)) << nFrac;
               rem_d    = '0;
               quot_d   = '0;
               cnt_d    = CW'(N);
               ovf_d    = 1'b0;
               dz_d     = 1'b0;
               state_d  = sm_is_zero(64'(b), nBits) ? DONE : DIV;
            end
         end
         DIV: begin
            dvd_d  = dvd_q << 1;
            rem_d  = step_rem;
            quot_d = (quot_q << 1) | N'(step_q);
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            dz_d    = zdiv_q;
            state_d = IDLE;
            if (zdiv_q) begin
               ovf_d = 1'b0;
               res_d = a_zero_q ? '0 : {a_sign_q, {M{1'b1}}};
            end else begin
               ovf_d = |(quot_q >> M);
               res_d = {sign_q & (|mag), mag};
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         dvd_q    <= '0;
         quot_q   <= '0;
         rem_q    <= '0;
         dsr_q    <= '0;
         sign_q   <= 1'b0;
         a_sign_q <= 1'b0;
         a_zero_q <= 1'b0;
         zdiv_q   <= 1'b0;
         done_q   <= 1'b0;
         res_q    <= '0;
         ovf_q    <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dvd_q    <= dvd_d;
         quot_q   <= quot_d;
         rem_q    <= rem_d;
         dsr_q    <= dsr_d;
         sign_q   <= sign_d;
         a_sign_q <= a_sign_d;
         a_zero_q <= a_zero_d;
         zdiv_q   <= zdiv_d;
         done_q   <= done_d;
         res_q    <= res_d;
         ovf_q    <= ovf_d;
         dz_q     <= dz_d;
      end
   end

   // The done cycle is not a ready cycle: a new start is taken the cycle after.
   assign ready = (state_q == IDLE) && !done_q;
   assign done  = done_q;
   assign res   = res_q;
   assign ovf   = ovf_q;
   assign dz    = dz_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed bench for fixed_point_divider with a result scoreboard and latency checks.
module tb_fixed_point_divider;

   typedef struct packed {
      logic [31:0] res;
      logic        ovf;
      logic        dz;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        ready, done, ovf, dz;
   logic [31:0] res;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   fixed_point_divider #(.nBits(32), .nFrac(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .ready (ready),
      .done  (done),
      .res   (res),
      .ovf   (ovf),
      .dz    (dz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
      exp_t        e;
      logic [63:0] q;
      logic [30:0] m;
      if (y[30:0] == 31'd0) begin
         e.dz  = 1'b1;
         e.ovf = 1'b0;
         e.res = (x[30:0] == 31'd0) ? 32'd0 : {x[31], 31'h7FFFFFFF};
      end else begin
         q     = ({33'd0, x[30:0]} << 16) / {33'd0, y[30:0]};
         e.dz  = 1'b0;
         e.ovf = |q[63:31];
         m     = e.ovf ? 31'h7FFFFFFF : q[30:0];
         e.res = {(x[31] ^ y[31]) & (m != 31'd0), m};
      end
      return e;
   endfunction

   // Called at a negedge; returns at the negedge after the done-cycle follow-up checks.
   task automatic run(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                      input exp_t e, input int poke);
      int   cyc;
      int   lat;
      bit   seen;
      bit   rdy_low;
      exp_t got;
      exp_t want;
      lat = (tbv[30:0] == 31'd0) ? 1 : 48;
      sb.push_back(e);
      a = ta;
      b = tbv;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 0;
      seen = 1'b0;
      rdy_low = 1'b1;
      while (!seen && cyc < 200) begin
         if (poke != 0 && cyc == poke) begin
            a = 32'h00050000;
            b = 32'h00010000;
            start = 1'b1;
         end
         @(posedge clk);
         cyc++;
         #1 start = 1'b0;
         a = $urandom;
         b = $urandom;
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
         else if (ready !== 1'b0) rdy_low = 1'b0;
      end
      chk({tag, " done seen"}, 64'(seen), 64'd1);
      chk({tag, " latency"}, 64'(cyc), 64'(lat));
      chk({tag, " ready low while busy"}, 64'(rdy_low), 64'd1);
      chk({tag, " ready in done cycle"}, 64'(ready), 64'd0);
      if (sb.size() == 0) begin
         chk({tag, " scoreboard entry"}, 64'd0, 64'd1);
      end else begin
         want = sb.pop_front();
         got  = '{res: res, ovf: ovf, dz: dz};
         chk({tag, " res"}, 64'(got.res), 64'(want.res));
         chk({tag, " ovf"}, 64'(got.ovf), 64'(want.ovf));
         chk({tag, " dz"}, 64'(got.dz), 64'(want.dz));
      end
      @(negedge clk);
      chk({tag, " done one cycle"}, 64'(done), 64'd0);
      chk({tag, " ready after done"}, 64'(ready), 64'd1);
   endtask

   initial begin
      int   extra_done;
      exp_t e;
      #2;
      chk("reset ready", 64'(ready), 64'd1);
      chk("reset done", 64'(done), 64'd0);
      chk("reset res", 64'(res), 64'd0);
      chk("reset ovf", 64'(ovf), 64'd0);
      chk("reset dz", 64'(dz), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run("3/2", 32'h00030000, 32'h00020000, '{res: 32'h00018000, ovf: 1'b0, dz: 1'b0}, 0);
      run("-1/4", 32'h80010000, 32'h00040000, '{res: 32'h80004000, ovf: 1'b0, dz: 1'b0}, 0);
      run("1/3", 32'h00010000, 32'h00030000, '{res: 32'h00005555, ovf: 1'b0, dz: 1'b0}, 0);
      run("sat", 32'h7FFF0000, 32'h00000001, '{res: 32'h7FFFFFFF, ovf: 1'b1, dz: 1'b0}, 0);
      run("no neg zero", 32'h00000001, 32'h80020000, '{res: 32'h00000000, ovf: 1'b0, dz: 1'b0}, 0);
      run("dz pos", 32'h00050000, 32'h80000000, '{res: 32'h7FFFFFFF, ovf: 1'b0, dz: 1'b1}, 0);
      run("dz zero", 32'h80000000, 32'h00000000, '{res: 32'h00000000, ovf: 1'b0, dz: 1'b1}, 0);
      run("dz neg", 32'h80000003, 32'h00000000, '{res: 32'hFFFFFFFF, ovf: 1'b0, dz: 1'b1}, 0);
      run("ignored start", 32'h00030000, 32'h00020000,
          '{res: 32'h00018000, ovf: 1'b0, dz: 1'b0}, 10);
      extra_done = 0;
      repeat (60) begin
         @(negedge clk);
         if (done === 1'b1) extra_done++;
      end
      chk("ignored start no extra done", 64'(extra_done), 64'd0);

      for (int i = 0; i < 3; i++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         ra = $urandom;
         rb = {$urandom_range(1, 0) == 1 ? 1'b1 : 1'b0, 31'($urandom_range(32'h00FFFFFF, 1))};
         e  = model(ra, rb);
         run("random", ra, rb, e, 0);
      end

      // Abort a division mid-flight; the result of the previous op must be cleared at once.
      run("pre-reset", 32'h00030000, 32'h00020000, '{res: 32'h00018000, ovf: 1'b0, dz: 1'b0}, 0);
      a = 32'h00030000;
      b = 32'h00020000;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (19) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("mid reset res", 64'(res), 64'd0);
      chk("mid reset ready", 64'(ready), 64'd1);
      chk("mid reset done", 64'(done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      extra_done = 0;
      repeat (60) begin
         @(negedge clk);
         if (done === 1'b1) extra_done++;
      end
      chk("aborted op no done", 64'(extra_done), 64'd0);
      run("post-reset 1/2", 32'h00010000, 32'h00020000,
          '{res: 32'h00008000, ovf: 1'b0, dz: 1'b0}, 0);

      chk("scoreboard drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
